// File: rtl/rr_arbiter8.sv
// Round-robin arbiter feeding the 8-to-3 encoder stage: registered one-hot
// grant with valid/ready handshake. Ports: clk, rst_n, req, gnt_ready, gnt, gnt_valid.
module rr_arbiter8 #(
  parameter int N        = 8,
  parameter int PTR_INIT = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       gnt_ready,
  output logic [7:0] gnt,
  output logic       gnt_valid
);

  localparam logic [7:0] MASK = 8'((16'd1 << N) - 16'd1);
  localparam logic [2:0] P0   = 3'(PTR_INIT);
  localparam logic [2:0] LAST = 3'(N - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state_q, state_d;
  logic [7:0] gnt_q, gnt_d;
  logic [2:0] ptr_q, ptr_d;
  logic [2:0] idx;
  logic [7:0] nxt;

  // First requester at or after p, wrapping modulo N.
  function automatic logic [7:0] sel(
    input logic [7:0] r,
    input logic [2:0] p
  );
    logic [7:0] s;
    logic       hit;
    logic [2:0] k;
    s   = '0;
    hit = 1'b0;
    for (int i = 0; i < N; i++) begin
      k = 3'((32'(p) + i) % N);
      if (!hit && r[k]) begin
        s[k] = 1'b1;
        hit  = 1'b1;
      end
    end
    return s;
  endfunction

  always_comb begin
    idx = '0;
    for (int i = 0; i < 8; i++)
      if (gnt_q[i]) idx = 3'(i);
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    nxt     = '0;
    unique case (state_q)
      IDLE: begin
        if (|(req & MASK)) begin
          gnt_d   = sel(req, ptr_q);
          state_d = GRANT;
        end else begin
          gnt_d = '0;
        end
      end
      GRANT: begin
        if (gnt_ready) begin
          ptr_d = (idx == LAST) ? 3'd0 : idx + 3'd1;
          nxt   = sel(req, ptr_d);
          gnt_d = nxt;
          if (nxt == '0) state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ptr_q   <= P0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = (state_q == GRANT);

endmodule

// File: tb/tb_rr_arbiter8.sv
// Randomized + directed bench for rr_arbiter8 against a
// behavioural round-robin model.
module tb_rr_arbiter8;

  localparam int N  = 8;
  localparam int P0 = 0;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic       gnt_ready;
  logic [7:0] gnt;
  logic       gnt_valid;

  int errs = 0;
  int chks = 0;

  bit m_valid = 1'b0;
  int m_idx   = 0;
  int m_ptr   = P0;

  always #5 clk = ~clk;

  rr_arbiter8 #(.N(N), .PTR_INIT(P0)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .gnt_ready(gnt_ready),
    .gnt      (gnt),
    .gnt_valid(gnt_valid)
  );

  task automatic expect_eq(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    chks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input logic [7:0] r, input int p);
    for (int i = 0; i < N; i++)
      if (r[(p + i) % N]) return (p + i) % N;
    return -1;
  endfunction

  task automatic model(input logic [7:0] r, input bit rd, input bit rn);
    int p;
    if (!rn) begin
      m_valid = 1'b0;
      m_ptr   = P0;
    end else if (!m_valid) begin
      p = pick(r, m_ptr);
      if (p >= 0) begin
        m_idx   = p;
        m_valid = 1'b1;
      end
    end else if (rd) begin
      m_ptr = (m_idx + 1) % N;
      p = pick(r, m_ptr);
      if (p >= 0) m_idx = p;
      else m_valid = 1'b0;
    end
  endtask

  task automatic step(input logic [7:0] r, input bit rd, input bit rn);
    logic [7:0] eg;
    req       = r;
    gnt_ready = rd;
    rst_n     = rn;
    @(posedge clk);
    model(r, rd, rn);
    #1;
    eg = m_valid ? (8'h01 << m_idx) : 8'h00;
    expect_eq("gnt", 32'(gnt), 32'(eg));
    expect_eq("valid", 32'(gnt_valid), 32'(m_valid));
    expect_eq("onehot0", 32'($onehot0(gnt)), 32'd1);
  endtask

  logic [7:0] rot [0:8];
  int         enc;

  initial begin
    rot = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
            8'h20, 8'h40, 8'h80, 8'h01};
    req = '0;
    gnt_ready = 1'b0;
    rst_n = 1'b0;
    #2;

    // reset with everything requesting
    step(8'hFF, 1'b1, 1'b0);
    expect_eq("rst_gnt", 32'(gnt), 32'h0);
    step(8'hFF, 1'b1, 1'b0);
    expect_eq("rst_valid", 32'(gnt_valid), 32'h0);
    step(8'hFF, 1'b1, 1'b1);
    expect_eq("rst_first", 32'(gnt), 32'h01);
    step(8'h00, 1'b1, 1'b1);

    // single request
    step(8'h04, 1'b1, 1'b1);
    expect_eq("single", 32'(gnt), 32'h04);
    enc = 0;
    for (int i = 0; i < 8; i++) if (gnt[i]) enc = i;
    expect_eq("enc_d", 32'(enc), 32'd2);
    step(8'h00, 1'b1, 1'b1);
    expect_eq("single_end", 32'(gnt_valid), 32'h0);

    // full rotation from a fresh pointer
    step(8'hFF, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) begin
      step(8'hFF, 1'b1, 1'b1);
      expect_eq("rot", 32'(gnt), 32'(rot[i]));
    end

    // wrap fairness between 0 and 7
    step(8'h81, 1'b1, 1'b1);
    expect_eq("wrap0", 32'(gnt), 32'h80);
    step(8'h81, 1'b1, 1'b1);
    expect_eq("wrap1", 32'(gnt), 32'h01);
    step(8'h81, 1'b1, 1'b1);
    expect_eq("wrap2", 32'(gnt), 32'h80);

    // backpressure
    step(8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(8'h30, 1'b0, 1'b1);
      expect_eq("bp_hold", 32'(gnt), 32'h10);
    end
    step(8'h20, 1'b0, 1'b1);
    expect_eq("bp_drop", 32'(gnt), 32'h10);
    step(8'h20, 1'b1, 1'b1);
    expect_eq("bp_next", 32'(gnt), 32'h20);
    step(8'h00, 1'b1, 1'b1);

    // reset mid-grant
    step(8'h00, 1'b1, 1'b0);
    step(8'h08, 1'b0, 1'b1);
    expect_eq("mid_gnt", 32'(gnt), 32'h08);
    step(8'hFF, 1'b1, 1'b0);
    expect_eq("mid_rst", 32'(gnt), 32'h00);
    step(8'hFF, 1'b1, 1'b1);
    expect_eq("mid_after", 32'(gnt), 32'h01);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      logic [7:0] r;
      r = 8'($urandom);
      if ($urandom_range(3) == 0) r = 8'h00;
      if ($urandom_range(3) == 0) r = 8'($urandom) & 8'($urandom);
      step(r, 1'($urandom_range(3) != 0), ($urandom_range(60) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end

endmodule
